// File: rtl/alm_pkg.sv
// Shared definitions for the ALM-SOA multiplier datapath.
package alm_pkg;

  localparam int N_DEFAULT = 16;

  // Width of a characteristic (leading-one index) for an n-bit operand.
  function automatic int kw_of(input int n);
    return $clog2(n);
  endfunction

  // One operand in Mitchell log form, shared with the downstream adder stage.
  typedef struct packed {
    logic [$clog2(N_DEFAULT)-1:0] k;
    logic [N_DEFAULT-2:0]         f;
    logic                         zero;
  } log_operand_t;

endpackage

// File: rtl/alm_lod.sv
// Combinational leading-one detector: index of the highest set bit plus a zero flag.
module alm_lod
  import alm_pkg::*;
#(
  parameter  int N  = N_DEFAULT,
  localparam int KW = kw_of(N)
) (
  input  logic [N-1:0]  x_i,
  output logic [KW-1:0] k_o,
  output logic          zero_o
);

  // Ascending scan so the highest set bit is the last one written; x==0 leaves k at 0.
  always_comb begin
    k_o    = '0;
    zero_o = (x_i == '0);
    for (int i = 0; i < N; i++) begin
      if (x_i[i]) k_o = KW'(i);
    end
  end

endmodule

// File: rtl/alm_log_convert.sv
// Two-stage log-conversion front end: leading-one detection, then normalisation.
module alm_log_convert
  import alm_pkg::*;
#(
  parameter  int N  = N_DEFAULT,
  localparam int KW = kw_of(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [KW-1:0] k_a,
  output logic [KW-1:0] k_b,
  output logic [N-2:0]  f_a,
  output logic [N-2:0]  f_b,
  output logic          zero
);

  // Stage 1 only keeps the bits below the MSB: the MSB is always shifted out
  // of the fraction, and its contribution is already captured in k.
  logic          v1_q;
  logic [N-2:0]  a1_q, b1_q;
  logic [KW-1:0] ka1_q, kb1_q;
  logic          za1_q, zb1_q;

  logic          v2_q;
  logic [KW-1:0] k_a_q, k_b_q, k_a_d, k_b_d;
  logic [N-2:0]  f_a_q, f_b_q, f_a_d, f_b_d;
  logic          zero_q, zero_d;

  logic [KW-1:0] ka_lod, kb_lod;
  logic          za_lod, zb_lod;
  logic          ready1, ready2;

  alm_lod #(.N(N)) u_lod_a (.x_i(a), .k_o(ka_lod), .zero_o(za_lod));
  alm_lod #(.N(N)) u_lod_b (.x_i(b), .k_o(kb_lod), .zero_o(zb_lod));

  assign ready2    = !v2_q || out_ready;
  assign ready1    = !v1_q || ready2;
  assign in_ready  = ready1;
  assign out_valid = v2_q;
  assign k_a       = k_a_q;
  assign k_b       = k_b_q;
  assign f_a       = f_a_q;
  assign f_b       = f_b_q;
  assign zero      = zero_q;

  // Stage 1 register: capture operands with their leading-one info on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      ka1_q <= '0;
      kb1_q <= '0;
      za1_q <= 1'b0;
      zb1_q <= 1'b0;
    end else if (ready1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        a1_q  <= a[N-2:0];
        b1_q  <= b[N-2:0];
        ka1_q <= ka_lod;
        kb1_q <= kb_lod;
        za1_q <= za_lod;
        zb1_q <= zb_lod;
      end
    end
  end

  // Normalisation: left-align the bits under the leading one; zero operands read 0.
  always_comb begin
    k_a_d  = za1_q ? '0 : ka1_q;
    k_b_d  = zb1_q ? '0 : kb1_q;
    f_a_d  = za1_q ? '0 : (a1_q << (KW'(N-1) - ka1_q));
    f_b_d  = zb1_q ? '0 : (b1_q << (KW'(N-1) - kb1_q));
    zero_d = za1_q | zb1_q;
  end

  // Stage 2 register: holds the result steady while the adder stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      k_a_q  <= '0;
      k_b_q  <= '0;
      f_a_q  <= '0;
      f_b_q  <= '0;
      zero_q <= 1'b0;
    end else if (ready2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        k_a_q  <= k_a_d;
        k_b_q  <= k_b_d;
        f_a_q  <= f_a_d;
        f_b_q  <= f_b_d;
        zero_q <= zero_d;
      end
    end
  end

endmodule

// File: tb/tb_alm_log_convert.sv
// Self-checking bench for alm_log_convert (N=16) against a log2-based reference model.
module tb_alm_log_convert;

  typedef struct packed {
    logic [3:0]  ka;
    logic [3:0]  kb;
    logic [14:0] fa;
    logic [14:0] fb;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  k_a, k_b;
  logic [14:0] f_a, f_b;
  logic        zero;

  int checks = 0;
  int failures = 0;
  res_t exp_q[$];

  alm_log_convert dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .k_a(k_a), .k_b(k_b), .f_a(f_a), .f_b(f_b), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // floor(log2(x)) for x>0, 0 for x==0
  function automatic int lead(input logic [15:0] x);
    int k;
    k = 0;
    while (k < 15 && (x >> (k + 1)) != 0) k++;
    return k;
  endfunction

  // x / 2^k - 1, expressed in 15 fractional bits
  function automatic logic [14:0] frac(input logic [15:0] x);
    int k;
    logic [31:0] t;
    if (x == 0) return '0;
    k = lead(x);
    t = (32'(x) - (32'd1 << k)) << (15 - k);
    return t[14:0];
  endfunction

  function automatic res_t model(input logic [15:0] av, input logic [15:0] bv);
    res_t r;
    r.ka = 4'(lead(av));
    r.kb = 4'(lead(bv));
    r.fa = frac(av);
    r.fb = frac(bv);
    r.z  = (av == 0) || (bv == 0);
    return r;
  endfunction

  function automatic logic [15:0] rand_op();
    if ($urandom_range(0, 15) == 0) return 16'h0000;
    return 16'($urandom) >> $urandom_range(0, 15);
  endfunction

  // Drive one cycle at the falling edge and observe just before the next rising edge.
  task automatic drive(input logic iv, input logic [15:0] av, input logic [15:0] bv,
                       input logic ordy, output logic acc, output res_t o,
                       output logic ov, output logic ir);
    @(negedge clk);
    in_valid  = iv;
    a         = av;
    b         = bv;
    out_ready = ordy;
    #1;
    ir  = in_ready;
    ov  = out_valid;
    acc = iv && in_ready;
    o   = '{ka: k_a, kb: k_b, fa: f_a, fb: f_b, z: zero};
    if (acc) exp_q.push_back(model(av, bv));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if ({k_a, k_b, f_a, f_b, zero} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", {k_a, k_b, f_a, f_b, zero});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] va[4] = '{16'h00C0, 16'h8000, 16'hFFFF, 16'h0000};
    logic [15:0] vb[4] = '{16'h0005, 16'h0001, 16'h0001, 16'h1234};
    res_t ve[4] = '{
      '{ka: 4'd7,  kb: 4'd2,  fa: 15'h4000, fb: 15'h2000, z: 1'b0},
      '{ka: 4'd15, kb: 4'd0,  fa: 15'h0000, fb: 15'h0000, z: 1'b0},
      '{ka: 4'd15, kb: 4'd0,  fa: 15'h7FFF, fb: 15'h0000, z: 1'b0},
      '{ka: 4'd0,  kb: 4'd12, fa: 15'h0000, fb: 15'h11A0, z: 1'b1}};
    logic acc, ov, ir;
    res_t o;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, va[i], vb[i], 1'b1, acc, o, ov, ir);
      drive(1'b0, '0, '0, 1'b1, acc, o, ov, ir);
      checks++;
      if (ov !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d_latency1: out_valid got %b expected 0", i, ov);
      end
      drive(1'b0, '0, '0, 1'b1, acc, o, ov, ir);
      checks++;
      if (ov !== 1'b1) begin
        failures++;
        $display("FAIL vec%0d_latency2: out_valid got %b expected 1", i, ov);
      end
      checks++;
      if (o !== ve[i]) begin
        failures++;
        $display("FAIL vec%0d_value: got %h expected %h", i, o, ve[i]);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pa[4], pb[4];
    logic acc, ov, ir;
    res_t o, prev, e;
    int idx;
    idx = 0;
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      pa[i] = rand_op();
      pb[i] = rand_op();
    end
    for (int cyc = 0; cyc < 9; cyc++) begin
      drive(idx < 4, idx < 4 ? pa[idx] : 16'h0, idx < 4 ? pb[idx] : 16'h0,
            cyc >= 3, acc, o, ov, ir);
      if (acc) idx++;
      if (cyc <= 2) begin
        checks++;
        if (ir !== (cyc < 2)) begin
          failures++;
          $display("FAIL bp_in_ready_c%0d: got %b expected %b", cyc, ir, cyc < 2);
        end
      end
      if (cyc == 3) begin
        checks++;
        if (o !== prev) begin
          failures++;
          $display("FAIL bp_hold: got %h expected %h", o, prev);
        end
      end
      checks++;
      if ((ov && out_ready) !== (cyc >= 3 && cyc <= 6)) begin
        failures++;
        $display("FAIL bp_emit_c%0d: got %b expected %b", cyc, ov && out_ready, cyc >= 3 && cyc <= 6);
      end
      if (ov && out_ready) begin
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL bp_order_c%0d: got %h expected %h", cyc, o, e);
        end
      end
      prev = o;
    end
  endtask

  task automatic test_random();
    logic acc, ov, ir, stalled, iv, ordy;
    res_t o, prev, e;
    int sent, cyc;
    sent = 0;
    cyc = 0;
    stalled = 1'b0;
    prev = '0;
    while (sent < 10000 && cyc < 60000) begin
      iv = ($urandom_range(0, 3) != 0);
      ordy = 1'($urandom_range(0, 1));
      drive(iv, rand_op(), rand_op(), ordy, acc, o, ov, ir);
      if (acc) sent++;
      if (stalled) begin
        checks++;
        if (ov !== 1'b1 || o !== prev) begin
          failures++;
          $display("FAIL rnd_hold_c%0d: got %b/%h expected 1/%h", cyc, ov, o, prev);
        end
      end
      if (ov && ordy) begin
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL rnd_data_c%0d: got %h expected %h", cyc, o, e);
        end
      end
      stalled = ov && !ordy;
      prev = o;
      cyc++;
    end
    checks++;
    if (sent != 10000) begin
      failures++;
      $display("FAIL rnd_budget: sent %0d expected 10000", sent);
    end
    // full-rate phase: after the 2-cycle fill every cycle must emit
    for (int i = 0; i < 300; i++) begin
      drive(i < 298, rand_op(), rand_op(), 1'b1, acc, o, ov, ir);
      if (i >= 4) begin
        checks++;
        if (ov !== 1'b1) begin
          failures++;
          $display("FAIL rnd_bubble_%0d: out_valid got %b expected 1", i, ov);
        end
      end
      if (ov) begin
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL rnd_fullrate_%0d: got %h expected %h", i, o, e);
        end
      end
    end
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
      drive(1'b0, '0, '0, 1'b1, acc, o, ov, ir);
      if (ov) begin
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL rnd_drain_%0d: got %h expected %h", i, o, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rnd_leftover: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_full();
    logic acc, ov, ir;
    res_t o, e;
    drive(1'b1, 16'h0F00, 16'h0033, 1'b0, acc, o, ov, ir);
    drive(1'b1, 16'h0101, 16'h7000, 1'b0, acc, o, ov, ir);
    drive(1'b0, '0, '0, 1'b0, acc, o, ov, ir);
    checks++;
    if (ir !== 1'b0 || ov !== 1'b1) begin
      failures++;
      $display("FAIL rstfull_fill: in_ready/out_valid got %b/%b expected 0/1", ir, ov);
    end
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstfull_flags: out_valid/in_ready got %b/%b expected 0/1", out_valid, in_ready);
    end
    checks++;
    if ({k_a, k_b, f_a, f_b, zero} !== '0) begin
      failures++;
      $display("FAIL rstfull_outputs: got %h expected 0", {k_a, k_b, f_a, f_b, zero});
    end
    drive(1'b0, '0, '0, 1'b1, acc, o, ov, ir);
    checks++;
    if (ov !== 1'b0) begin
      failures++;
      $display("FAIL rstfull_ghost: out_valid got %b expected 0", ov);
    end
    drive(1'b1, 16'h0300, 16'h0009, 1'b1, acc, o, ov, ir);
    drive(1'b0, '0, '0, 1'b1, acc, o, ov, ir);
    drive(1'b0, '0, '0, 1'b1, acc, o, ov, ir);
    e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
    checks++;
    if (ov !== 1'b1 || o !== e) begin
      failures++;
      $display("FAIL rstfull_next: got %b/%h expected 1/%h", ov, o, e);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_random();
    test_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
